// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game datapath: memory geometry, colour codes
// and the playback FSM state encoding.
package simon_pkg;

    localparam int DATA_W = 6;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ON, OFF, DONE} play_state_t;

    typedef logic [DATA_W-1:0] colour_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by the ON and OFF display phases; it parks at
// zero once it gets there and flags that condition.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays back the first `level` colours of the sequence memory on `led`, one
// fetch/latch/on/off round per element, then pulses `done`.
module sequence_player
    import simon_pkg::*;
#(
    parameter int DATA_W     = simon_pkg::DATA_W,
    parameter int ADDR_W     = simon_pkg::ADDR_W,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   level,
    output logic [ADDR_W-1:0] r_ptr,
    output logic              r_en,
    input  logic [DATA_W-1:0] data_Out,
    output logic [DATA_W-1:0] led,
    output logic              busy,
    output logic              done
);
    localparam int TW = $clog2(maxOf(ON_CYCLES, OFF_CYCLES) + 1);

    play_state_t       state_q, state_d;
    logic [ADDR_W:0]   index_q, index_d;
    logic [ADDR_W:0]   lvl_q, lvl_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic              r_en_q, busy_q, done_q;

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_zero;

    phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Outputs are registered from the next state so each one is visible for
    // exactly the cycle its state occupies.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        lvl_d    = lvl_q;
        led_d    = led_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lvl_d   = level;
                    index_d = '0;
                    state_d = (level == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                led_d    = data_Out;
                tmr_load = 1'b1;
                tmr_val  = TW'(ON_CYCLES - 1);
                state_d  = ON;
            end
            ON: begin
                if (tmr_zero) begin
                    led_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(OFF_CYCLES - 1);
                    state_d  = OFF;
                end
            end
            OFF: begin
                if (tmr_zero) begin
                    index_d = index_q + 1'b1;
                    state_d = (index_d == lvl_q) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d  = IDLE;
            index_d  = '0;
            led_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end
    end

    assign r_ptr_d = (state_d == FETCH) ? index_d[ADDR_W-1:0] : r_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            lvl_q   <= '0;
            led_q   <= '0;
            r_ptr_q <= '0;
            r_en_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            lvl_q   <= lvl_d;
            led_q   <= led_d;
            r_ptr_q <= r_ptr_d;
            r_en_q  <= (state_d == FETCH);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign r_ptr = r_ptr_q;
    assign r_en  = r_en_q;
    assign led   = led_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench for sequence_player: a registered memory model, a
// read/colour scoreboard and a cycle-by-cycle timeline of r_en/led/done/busy.
module tb_sequence_player;
    import simon_pkg::*;

    localparam int ON_C   = 4;
    localparam int OFF_C  = 2;
    localparam int PERIOD = 2 + ON_C + OFF_C;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   level;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_en;
    logic [DATA_W-1:0] data_Out;
    logic [DATA_W-1:0] led;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [DEPTH];

    int nChecks  = 0;
    int nFail    = 0;
    int doneSeen = 0;
    int addrQ[$];
    int ledQ[$];
    logic [DATA_W-1:0] prevLed = '0;

    sequence_player #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .level    (level),
        .r_ptr    (r_ptr),
        .r_en     (r_en),
        .data_Out (data_Out),
        .led      (led),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory with a registered read port: data follows the edge that samples r_en.
    always @(posedge clk) begin
        if (r_en) data_Out <= mem[r_ptr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare any read address or new colour against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (r_en) begin
            if (addrQ.size() == 0) begin
                nChecks++;
                nFail++;
                $error("[TB] FAIL unexpected_read: observed r_ptr %0d, required no read", r_ptr);
            end else begin
                checkOutput("r_ptr", 32'(r_ptr), addrQ.pop_front());
            end
        end
        if (led !== '0 && led !== prevLed) begin
            if (ledQ.size() == 0) begin
                nChecks++;
                nFail++;
                $error("[TB] FAIL unexpected_led: observed %0d, required 0", led);
            end else begin
                checkOutput("led_value", 32'(led), ledQ.pop_front());
            end
        end
        if (done === 1'b1) doneSeen++;
        prevLed = led;
    endtask

    // k counts edges after the edge that accepted start (k=0).
    task automatic checkStep(input int k, input int lvl);
        int e;
        int p;
        logic [31:0] expLed;
        e = k / PERIOD;
        p = k % PERIOD;
        expLed = '0;
        if (e < lvl && p >= 2 && p <= ON_C + 1) expLed = 32'(mem[e]);
        checkOutput($sformatf("r_en@%0d", k), 32'(r_en), 32'(e < lvl && p == 0));
        checkOutput($sformatf("led@%0d", k), 32'(led), expLed);
        checkOutput($sformatf("done@%0d", k), 32'(done), 32'(k == PERIOD * lvl));
        checkOutput($sformatf("busy@%0d", k), 32'(busy), 32'(k <= PERIOD * lvl));
    endtask

    task automatic applyStimulus(input int lvl, input int pulseAt, input int newLevel);
        int base;
        base = doneSeen;
        level = (ADDR_W+1)'(lvl);
        for (int e = 0; e < lvl; e++) begin
            addrQ.push_back(e);
            ledQ.push_back(int'(mem[e]));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checkStep(0, lvl);
        for (int k = 1; k <= PERIOD * lvl + 1; k++) begin
            if (k == pulseAt) begin
                start = 1'b1;
                level = (ADDR_W+1)'(newLevel);
            end
            tick();
            start = 1'b0;
            checkStep(k, lvl);
        end
        checkOutput("reads_left", 32'(addrQ.size()), 0);
        checkOutput("leds_left", 32'(ledQ.size()), 0);
        checkOutput("done_count", 32'(doneSeen - base), 1);
    endtask

    task automatic loadBasic();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[0] = 6'd5;
        mem[1] = 6'd17;
        mem[2] = 6'd42;
    endtask

    initial begin
        int base;
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        level = '0;
        loadBasic();

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_r_ptr", 32'(r_ptr), 0);
        checkOutput("rst_r_en", 32'(r_en), 0);
        checkOutput("rst_led", 32'(led), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        checkOutput("idle_busy", 32'(busy), 0);

        $display("[TB] basic playback, level 3");
        applyStimulus(3, 0, 3);

        $display("[TB] second start at T+8 and level change are ignored");
        applyStimulus(3, 8, 1);

        $display("[TB] level 0");
        applyStimulus(0, 0, 0);

        $display("[TB] level 32");
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 1);
        applyStimulus(32, 0, 32);

        $display("[TB] abort at T+5");
        loadBasic();
        level = 7'd3;
        for (int e = 0; e < 3; e++) begin
            addrQ.push_back(e);
            ledQ.push_back(int'(mem[e]));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_led", 32'(led), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_r_en", 32'(r_en), 0);
        checkOutput("abort_reads_left", 32'(addrQ.size()), 2);
        addrQ.delete();
        ledQ.delete();
        base = doneSeen;
        for (int k = 0; k < 12; k++) tick();
        checkOutput("abort_no_done", 32'(doneSeen - base), 0);
        checkOutput("abort_idle_busy", 32'(busy), 0);
        applyStimulus(3, 0, 3);

        $display("[TB] abort and start together");
        level = 7'd3;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_busy", 32'(busy), 0);
        checkOutput("abort_start_r_en", 32'(r_en), 0);
        tick();
        checkOutput("abort_start_busy2", 32'(busy), 0);

        $display("[TB] asynchronous reset mid-playback");
        for (int e = 0; e < 3; e++) begin
            addrQ.push_back(e);
            ledQ.push_back(int'(mem[e]));
        end
        base = doneSeen;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        checkOutput("pre_reset_led", 32'(led), 5);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_led", 32'(led), 0);
        checkOutput("arst_busy", 32'(busy), 0);
        checkOutput("arst_r_en", 32'(r_en), 0);
        checkOutput("arst_done", 32'(done), 0);
        checkOutput("arst_r_ptr", 32'(r_ptr), 0);
        addrQ.delete();
        ledQ.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        checkOutput("post_reset_busy", 32'(busy), 0);
        checkOutput("post_reset_r_en", 32'(r_en), 0);
        checkOutput("post_reset_led", 32'(led), 0);
        checkOutput("post_reset_no_done", 32'(doneSeen - base), 0);
        applyStimulus(1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
